// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between the instruction-fetch side and
//   the load/store side. Only one transaction is outstanding at a time.
//   Simultaneous requests are granted round-robin. The memory response is
//   routed back to the requester that owns the transaction. A watchdog aborts
//   any transaction that memory does not acknowledge within TIMEOUT cycles.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   iReq/iAddr -> iGnt               fetch request, combinational accept
//   iRvalid/iRdata                   one-cycle fetch response
//   dReq/dWe/dMode/dAddr/dWdata      load/store request
//   dGnt                             combinational load/store accept
//   dRvalid/dRdata                   one-cycle load/store response
//   err                              response was produced by a timeout abort
//   memReq/memWe/memMode/memAddr/memWdata   command to memory (grant cycle only)
//   memRvalid/memRdata               memory acknowledge / read data
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iGnt,
  output logic              iRvalid,
  output logic [DATA_W-1:0] iRdata,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [3:0]        dMode,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dGnt,
  output logic              dRvalid,
  output logic [DATA_W-1:0] dRdata,
  output logic              err,
  output logic              memReq,
  output logic              memWe,
  output logic [3:0]        memMode,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memRvalid,
  input  logic [DATA_W-1:0] memRdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t           state, stateNext;
  side_t            owner, lastGnt, winner;
  logic             ownerWe;
  logic             grant;
  logic             finish;
  logic             abort;
  logic [CNT_W-1:0] cnt;
  logic             iRvalidQ, dRvalidQ, errQ;
  logic [DATA_W-1:0] iRdataQ, dRdataQ;
  logic [DATA_W-1:0] respData;

  // Arbitration, command drive and next-state. Everything combinational is
  // gated by rst_n so the port stays quiet while reset is held.
  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    winner    = SIDE_I;
    finish    = 1'b0;
    abort     = 1'b0;
    iGnt      = 1'b0;
    dGnt      = 1'b0;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memMode   = '0;
    memAddr   = '0;
    memWdata  = '0;
    respData  = '0;

    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (iReq && dReq) begin
            grant  = 1'b1;
            winner = (lastGnt == SIDE_I) ? SIDE_D : SIDE_I;
          end else if (iReq) begin
            grant  = 1'b1;
            winner = SIDE_I;
          end else if (dReq) begin
            grant  = 1'b1;
            winner = SIDE_D;
          end

          if (grant) begin
            stateNext = BUSY;
            memReq    = 1'b1;
            if (winner == SIDE_D) begin
              dGnt     = 1'b1;
              memWe    = dWe;
              memMode  = dMode;
              memAddr  = dAddr;
              memWdata = dWdata;
            end else begin
              iGnt     = 1'b1;
              memAddr  = iAddr;
            end
          end
        end

        BUSY: begin
          // An acknowledge in the timeout cycle takes precedence over abort.
          if (memRvalid) begin
            finish    = 1'b1;
            stateNext = IDLE;
            respData  = ownerWe ? '0 : memRdata;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            abort     = 1'b1;
            stateNext = IDLE;
          end
        end

        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= SIDE_I;
      lastGnt  <= SIDE_I;
      ownerWe  <= 1'b0;
      cnt      <= '0;
      iRvalidQ <= 1'b0;
      dRvalidQ <= 1'b0;
      errQ     <= 1'b0;
      iRdataQ  <= '0;
      dRdataQ  <= '0;
    end else begin
      state    <= stateNext;
      iRvalidQ <= 1'b0;
      dRvalidQ <= 1'b0;
      errQ     <= 1'b0;

      if (grant) begin
        owner   <= winner;
        lastGnt <= winner;
        ownerWe <= (winner == SIDE_D) ? dWe : 1'b0;
        cnt     <= '0;
      end else if (state == BUSY && !finish && !abort) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (finish || abort) begin
        errQ <= abort;
        if (owner == SIDE_D) begin
          dRvalidQ <= 1'b1;
          dRdataQ  <= respData;
        end else begin
          iRvalidQ <= 1'b1;
          iRdataQ  <= respData;
        end
      end
    end
  end

  assign iRvalid = iRvalidQ;
  assign dRvalid = dRvalidQ;
  assign err     = errQ;
  assign iRdata  = iRdataQ;
  assign dRdata  = dRdataQ;

endmodule
